// File: rtl/wisc_pkg.sv
// wisc_pkg: constants and types shared by the WISC pipeline stages
// (fetch, decode, execute).
//   INST_W   - instruction / PC width
//   PC_INC   - byte increment between sequential instructions
//   OP_*     - opcode field values for inst[15:11]
//   NOP_INST - bubble encoding injected into pipeline registers
//   ifId_t   - IF/ID pipeline register bundle
package wisc_pkg;

   localparam int unsigned INST_W = 16;

   localparam logic [INST_W-1:0] PC_INC = 16'd2;

   localparam logic [4:0] OP_HALT = 5'b00000;
   localparam logic [4:0] OP_NOP  = 5'b00001;

   localparam logic [INST_W-1:0] NOP_INST = {OP_NOP, 11'b0};

   typedef struct packed {
      logic              valid;
      logic [INST_W-1:0] inst;
      logic [INST_W-1:0] pc;
      logic [INST_W-1:0] pcInc;
   } ifId_t;

   function automatic logic [4:0] opcodeOf(input logic [INST_W-1:0] inst);
      return inst[15:11];
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: signals between the fetch stage and its neighbours.
//   stall_i / redirect_i / redirect_pc_i - control from decode/execute
//   imem_addr_o / imem_data_i            - instruction-memory port
//   pc_o, if_id_*, halted_o              - PC, IF/ID register, halt status
// Modports: master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;
   import wisc_pkg::*;

   logic              stall_i;
   logic              redirect_i;
   logic [INST_W-1:0] redirect_pc_i;
   logic [INST_W-1:0] imem_addr_o;
   logic [INST_W-1:0] imem_data_i;
   logic [INST_W-1:0] pc_o;
   logic              if_id_valid_o;
   logic [INST_W-1:0] if_id_inst_o;
   logic [INST_W-1:0] if_id_pc_o;
   logic [INST_W-1:0] if_id_pc_inc_o;
   logic              halted_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
      output imem_addr_o, pc_o, if_id_valid_o, if_id_inst_o,
             if_id_pc_o, if_id_pc_inc_o, halted_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_data_i,
      input  imem_addr_o, pc_o, if_id_valid_o, if_id_inst_o,
             if_id_pc_o, if_id_pc_inc_o, halted_o
   );

endinterface

// File: rtl/pipe_reg.sv
// pipe_reg: generic pipeline register.
//   clk, rst - clock, synchronous active-high reset (loads RST_VAL)
//   en       - load d when high (driven with ~stall)
//   flush    - load RST_VAL regardless of en
//   d, q     - data in / registered data out
// Priority per edge: rst > flush > en.
module pipe_reg #(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the WISC pipeline.
//   clk, rst - clock, synchronous active-high reset
//   bus      - fetch_stage_if.master: stall/redirect control, imem port,
//              PC, IF/ID register outputs and halt status
// Owns the PC and a RUN/HALTED FSM; the IF/ID bundle lives in pipe_reg.
// Edge priority: rst > redirect > stall > state action.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800,
   parameter logic [4:0]  HALT_OPC = 5'b00000
) (
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master bus
);
   import wisc_pkg::*;

   typedef enum logic {RUN, HALTED} fetchState_t;

   localparam ifId_t BUBBLE = '{valid: 1'b0, inst: NOP_INST, pc: '0, pcInc: '0};

   fetchState_t       state, stateNext;
   logic [INST_W-1:0] pc, pcNext, pcInc, pcTarget;
   logic              isHalt;
   ifId_t             ifIdD, ifIdQ;

   assign pcInc    = pc + PC_INC;
   assign pcTarget = bus.redirect_pc_i & ~16'd1;
   assign isHalt   = (opcodeOf(bus.imem_data_i) == HALT_OPC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         pc    <= RESET_PC;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
      end
   end

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      if (bus.redirect_i) begin
         stateNext = RUN;
         pcNext    = pcTarget;
      end else if (!bus.stall_i && state == RUN) begin
         if (isHalt) begin
            stateNext = HALTED;
         end else begin
            pcNext = pcInc;
         end
      end
   end

   // Redirect maps to the pipe_reg flush, stall to its enable, so the
   // register's own priority reproduces redirect-over-stall.
   always_comb begin
      ifIdD = BUBBLE;
      if (state == RUN) begin
         ifIdD = '{valid: 1'b1, inst: bus.imem_data_i, pc: pc, pcInc: pcInc};
      end
   end

   pipe_reg #(
      .WIDTH   ($bits(ifId_t)),
      .RST_VAL (BUBBLE)
   ) u_ifId (
      .clk   (clk),
      .rst   (rst),
      .en    (~bus.stall_i),
      .flush (bus.redirect_i),
      .d     (ifIdD),
      .q     (ifIdQ)
   );

   assign bus.imem_addr_o    = pc;
   assign bus.pc_o           = pc;
   assign bus.if_id_valid_o  = ifIdQ.valid;
   assign bus.if_id_inst_o   = ifIdQ.inst;
   assign bus.if_id_pc_o     = ifIdQ.pc;
   assign bus.if_id_pc_inc_o = ifIdQ.pcInc;
   assign bus.halted_o       = (state == HALTED);

endmodule
